mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the CPU datapath and the word-only data memory. Accepts one byte, halfword or word request at a time over a valid/ready handshake and range- and alignment-checks the address. Sub-word stores are turned into read-modify-write sequences. Loads return lane-extracted, sign- or zero-extended data with a one-cycle response pulse. The memory side drives the data memory's `memory_write`/`memory_read`/`address`/`write_data` and consumes its combinational `read_data`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1001_0000: byte address of data-memory word 0.
- `DEPTH_WORDS`, default 4096: number of 32-bit words in data memory.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- `req_signed` in 1: sign-extend load result; ignored for stores and word loads.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_error` out 1: request rejected; valid with `resp_valid`.
- `memory_write` out 1: word write strobe to data memory.
- `memory_read` out 1: read enable to data memory.
- `address` out 32: word-aligned byte address, bits [1:0] = 0.
- `write_data` out 32: full word to write.
- `read_data` in 32: combinational read data from memory.

## Operation
- Byte order is little-endian. Byte lane = addr[1:0]. Halfword lane = addr[1], bits [15:0] or [31:16].
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. When `req_valid` is high, the unit latches addr, size, signed, write and wdata, then decodes:
  - Error if `req_size`=3, halfword with addr[0]=1, word with addr[1:0]≠0, or addr outside [BASE_ADDR, BASE_ADDR+4·DEPTH_WORDS). Next state is RESP with error=1. No memory strobe is issued.
  - Load → LOAD.
  - Word store → STORE.
  - Byte or halfword store → RMW_RD.
- LOAD: `memory_read`=1. Extract the lane from `read_data`, extend it, register the result. Next state is RESP.
- RMW_RD: `memory_read`=1. Register `read_data` with the new byte/half merged into its lane; other lanes are preserved. Next state is STORE.
- STORE: `memory_write`=1. `write_data` = latched wdata for word stores, merged word otherwise. Next state is RESP.
- RESP: `resp_valid`=1, `req_ready`=0. Next state is IDLE.
- `memory_read` and `memory_write` are never high in the same cycle.
- Outside its active state, `write_data`=0.
- `address` holds the latched word-aligned address; it is 0 after reset.

## Timing
- Counting from the accept cycle (cycle 0), `resp_valid` rises at:
  - Error: cycle 1.
  - Load or word store: cycle 2.
  - Sub-word store: cycle 3.
- Back-to-back requests: the next accept is possible the cycle after RESP. Throughput is therefore one request per 3 cycles for loads and word stores, and one per 4 cycles for sub-word stores.
- Reset values: `req_ready`=0 during the reset cycle and 1 afterwards. `resp_valid`, `resp_error`, `memory_write`, `memory_read`=0. `resp_rdata`, `address`, `write_data`=0.
- Reset mid-operation: the FSM goes to IDLE and the request is dropped with no response. `memory_write` is gated with `!rst`, so a STORE in the reset cycle never commits.
- `req_*` are sampled only on accept. Changes to them later are ignored.
- `resp_*` are registered outputs. `memory_*` outputs are decoded from state and latched data.

## Structure
- Package `mem_access_pkg` holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD),
  - the FSM state enum,
  - default BASE_ADDR / DEPTH_WORDS constants.
- Sub-module `mem_lane_align` is purely combinational and does both directions of lane handling:
  - Load side: extract and extend from (word, addr[1:0], size, signed).
  - Store side: merge from (old word, new data, addr[1:0], size).
- The top level contains the FSM, request latches and range check.

## Test plan
- Memory[0x10010004]=0x8844_22F0. Byte load, signed, addr 0x10010004 → resp_rdata=0xFFFF_FFF0, resp_valid at cycle 2. Same load unsigned → 0x0000_00F0.
- Halfword load, signed, addr 0x10010006 → 0xFFFF_8844.
- Byte store 0xAB to 0x10010005 → exactly one read cycle then one write cycle; memory word becomes 0x8844_ABF0; resp_valid at cycle 3.
- Word store 0x1234_5678 to 0x10010008 → no memory_read; one memory_write; resp at cycle 2. Word load from the same address → 0x1234_5678.
- Error cases, each giving resp_error=1 at cycle 1 with no memory strobes:
  - Halfword at 0x10010001.
  - Word at 0x10010002.
  - Word at 0x1001_4000.
  - req_size=3.
- rst asserted during the STORE cycle of a byte store → memory is unchanged, no resp_valid, and req_ready=1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size encodings, FSM states and memory-map defaults for mem_access_unit
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1001_0000;
  localparam int unsigned DEF_DEPTH_WORDS = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_STORE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] new_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_word_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  always_comb begin
    shamt        = {lane_i, 3'b000};
    shifted      = rd_word_i >> shamt;
    load_data_o  = rd_word_i;
    merge_word_o = rd_word_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
        case (lane_i)
          2'd0:    merge_word_o[7:0]   = new_data_i[7:0];
          2'd1:    merge_word_o[15:8]  = new_data_i[7:0];
          2'd2:    merge_word_o[23:16] = new_data_i[7:0];
          default: merge_word_o[31:24] = new_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        // Alignment is checked upstream, so only lane_i[1] selects the half.
        load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
        if (lane_i[1]) begin
          merge_word_o[31:16] = new_data_i[15:0];
        end else begin
          merge_word_o[15:0] = new_data_i[15:0];
        end
      end
      default: begin
        merge_word_o = new_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator with range/alignment checks and sub-word read-modify-write
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        memory_write,
  output logic        memory_read,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic [1:0]  size_q;
  logic        signed_q, write_q;
  logic        resp_valid_q, resp_error_q;
  logic [31:0] resp_rdata_q;

  logic        accept, req_err;
  logic        ready_raw, rd_raw, wr_raw;
  logic [31:0] wdata_raw;
  logic [31:0] load_data, merge_word;

  mem_lane_align u_align (
    .rd_word_i    (read_data),
    .lane_i       (addr_q[1:0]),
    .size_i       (size_q),
    .signed_i     (signed_q),
    .new_data_i   (wdata_q),
    .load_data_o  (load_data),
    .merge_word_o (merge_word)
  );

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3) req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0]) req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({1'b0, req_addr} < {1'b0, BASE_ADDR} || {1'b0, req_addr} >= LIMIT) req_err = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ready_raw = 1'b0;
    rd_raw    = 1'b0;
    wr_raw    = 1'b0;
    wdata_raw = '0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_err)                  state_d = ST_RESP;
          else if (!req_write)          state_d = ST_LOAD;
          else if (req_size == SZ_WORD) state_d = ST_STORE;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        rd_raw  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        rd_raw  = 1'b1;
        state_d = ST_STORE;
      end
      ST_STORE: begin
        wr_raw    = 1'b1;
        wdata_raw = (size_q == SZ_WORD) ? wdata_q : merge_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Gating with rst keeps a STORE caught by reset from committing to memory.
  assign req_ready    = ready_raw & ~rst;
  assign memory_read  = rd_raw & ~rst;
  assign memory_write = wr_raw & ~rst;
  assign write_data   = rst ? 32'h0 : wdata_raw;
  assign address      = {addr_q[31:2], 2'b00};
  assign resp_valid   = resp_valid_q;
  assign resp_error   = resp_error_q;
  assign resp_rdata   = resp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
        write_q  <= req_write;
      end
      if (state_q == ST_RMW_RD) merge_q <= merge_word;
      resp_valid_q <= (state_d == ST_RESP);
      resp_error_q <= accept & req_err;
      resp_rdata_q <= (state_q == ST_LOAD && !write_q) ? load_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized and directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam longint BASE  = 64'h1001_0000;
  localparam int     DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        memory_write, memory_read;
  logic [31:0] address, write_data, read_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [0:DEPTH-1];
  logic [31:0] shadow [0:DEPTH-1];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  vec_t plan [12];

  always #5 clk = ~clk;

  mem_access_unit #(
    .BASE_ADDR   (32'h1001_0000),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .memory_write (memory_write),
    .memory_read  (memory_read),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  function automatic bit in_mem(logic [31:0] a);
    return longint'(a) >= BASE && longint'(a) < BASE + 4 * DEPTH;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((longint'(a) - BASE) / 4);
  endfunction

  always_comb begin
    read_data = 32'h0;
    if (in_mem(address)) read_data = mem[widx(address)];
  end

  always @(posedge clk) begin
    if (memory_write && in_mem(address)) mem[widx(address)] <= write_data;
  end

  function automatic bit ref_error(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (longint'(a) % (64'd1 << sz) != 0) return 1'b1;
    return !in_mem(a);
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] word, logic [1:0] sz, logic sg, logic [31:0] a);
    longint nb  = 64'd1 << sz;
    longint off = longint'(a) % 4;
    longint v   = (longint'(word) >> (8 * off)) % (64'd1 << (8 * nb));
    if (sg && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] old, logic [1:0] sz, logic [31:0] wd, logic [31:0] a);
    longint nb   = 64'd1 << sz;
    longint off  = longint'(a) % 4;
    longint mask = ((64'd1 << (8 * nb)) - 1) << (8 * off);
    longint nv   = (longint'(old) & ~mask) | ((longint'(wd) << (8 * off)) & mask);
    return 32'(nv);
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr, output logic clash, output logic rdy_after);
    int guard = 0;
    rd = '0; er = 1'b0; lat = -1; nrd = 0; nwr = 0; clash = 1'b0; rdy_after = 1'b0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (memory_read) nrd++;
      if (memory_write) nwr++;
      if (memory_read && memory_write) clash = 1'b1;
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_error;
        break;
      end
    end
    @(negedge clk);
    rdy_after = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
    checks++; if ({resp_valid, resp_error, memory_write, memory_read} !== 4'b0)
      begin errors++; $display("FAIL reset_strobes got %b want 0000", {resp_valid, resp_error, memory_write, memory_read}); end
    checks++; if ({resp_rdata, address, write_data} !== 96'h0)
      begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", resp_rdata, address, write_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL post_reset_address got %h want 0", address); end
  endtask

  task automatic test_plan();
    logic [31:0] rd;
    logic er, clash, rdy;
    int lat, nrd, nwr;
    mem[1] = 32'h8844_22F0; shadow[1] = 32'h8844_22F0;
    plan[0]  = '{1'b0, 2'd0, 1'b1, 32'h1001_0004, 32'h0,         32'hFFFF_FFF0, 1'b0, 2, 1, 0};
    plan[1]  = '{1'b0, 2'd0, 1'b0, 32'h1001_0004, 32'h0,         32'h0000_00F0, 1'b0, 2, 1, 0};
    plan[2]  = '{1'b0, 2'd1, 1'b1, 32'h1001_0006, 32'h0,         32'hFFFF_8844, 1'b0, 2, 1, 0};
    plan[3]  = '{1'b1, 2'd0, 1'b0, 32'h1001_0005, 32'hFFFF_FFAB, 32'h0,         1'b0, 3, 1, 1};
    plan[4]  = '{1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0,         32'h8844_ABF0, 1'b0, 2, 1, 0};
    plan[5]  = '{1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'h1234_5678, 32'h0,         1'b0, 2, 0, 1};
    plan[6]  = '{1'b0, 2'd2, 1'b1, 32'h1001_0008, 32'h0,         32'h1234_5678, 1'b0, 2, 1, 0};
    plan[7]  = '{1'b0, 2'd1, 1'b0, 32'h1001_0001, 32'h0,         32'h0,         1'b1, 1, 0, 0};
    plan[8]  = '{1'b1, 2'd2, 1'b0, 32'h1001_0002, 32'h5555_5555, 32'h0,         1'b1, 1, 0, 0};
    plan[9]  = '{1'b0, 2'd2, 1'b0, 32'h1001_4000, 32'h0,         32'h0,         1'b1, 1, 0, 0};
    plan[10] = '{1'b0, 2'd3, 1'b0, 32'h1001_0000, 32'h0,         32'h0,         1'b1, 1, 0, 0};
    plan[11] = '{1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'hAAAA_AAAA, 32'h0,         1'b1, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      do_req(plan[i].w, plan[i].sz, plan[i].sg, plan[i].a, plan[i].wd, rd, er, lat, nrd, nwr, clash, rdy);
      if (plan[i].w && !plan[i].exp_err)
        shadow[widx(plan[i].a)] = ref_store(shadow[widx(plan[i].a)], plan[i].sz, plan[i].wd, plan[i].a);
      checks++; if (rd !== plan[i].exp_rd) begin errors++; $display("FAIL plan%0d_rdata got %h want %h", i, rd, plan[i].exp_rd); end
      checks++; if (er !== plan[i].exp_err) begin errors++; $display("FAIL plan%0d_error got %b want %b", i, er, plan[i].exp_err); end
      checks++; if (lat != plan[i].exp_lat) begin errors++; $display("FAIL plan%0d_latency got %0d want %0d", i, lat, plan[i].exp_lat); end
      checks++; if (nrd != plan[i].exp_nrd || nwr != plan[i].exp_nwr)
        begin errors++; $display("FAIL plan%0d_strobes got rd=%0d wr=%0d want rd=%0d wr=%0d", i, nrd, nwr, plan[i].exp_nrd, plan[i].exp_nwr); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL plan%0d_ready_after got %b want 1", i, rdy); end
    end
    checks++; if (mem[1] !== 32'h8844_ABF0) begin errors++; $display("FAIL plan_byte_store_word got %h want 8844abf0", mem[1]); end
    checks++; if (mem[2] !== 32'h1234_5678) begin errors++; $display("FAIL plan_word_store_word got %h want 12345678", mem[2]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd;
    logic er, clash, rdy, w, sg, exp_err;
    logic [1:0] sz;
    int lat, nrd, nwr, exp_lat, exp_nrd, exp_nwr, pick;
    for (int n = 0; n < 120; n++) begin
      w  = 1'($urandom);
      sz = 2'($urandom);
      sg = 1'($urandom);
      wd = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0)      a = 32'(BASE) - 32'($urandom_range(1, 8));
      else if (pick == 1) a = 32'(BASE + 4 * DEPTH) + 32'($urandom_range(0, 7));
      else                a = 32'(BASE) + 32'($urandom_range(0, 63));
      exp_err = ref_error(sz, a);
      exp_rd  = (exp_err || w) ? 32'h0 : ref_load(shadow[widx(a)], sz, sg, a);
      exp_lat = exp_err ? 1 : (w && sz != 2'd2) ? 3 : 2;
      exp_nrd = (exp_err || (w && sz == 2'd2)) ? 0 : 1;
      exp_nwr = (!exp_err && w) ? 1 : 0;
      do_req(w, sz, sg, a, wd, rd, er, lat, nrd, nwr, clash, rdy);
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata addr %h got %h want %h", n, a, rd, exp_rd); end
      checks++; if (er !== exp_err) begin errors++; $display("FAIL rand%0d_error addr %h got %b want %b", n, a, er, exp_err); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, exp_lat); end
      checks++; if (nrd != exp_nrd || nwr != exp_nwr || clash)
        begin errors++; $display("FAIL rand%0d_strobes got rd=%0d wr=%0d clash=%b want rd=%0d wr=%0d", n, nrd, nwr, clash, exp_nrd, exp_nwr); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rand%0d_ready_after got %b want 1", n, rdy); end
      if (!exp_err && w) begin
        shadow[widx(a)] = ref_store(shadow[widx(a)], sz, wd, a);
        checks++; if (mem[widx(a)] !== shadow[widx(a)])
          begin errors++; $display("FAIL rand%0d_mem addr %h got %h want %h", n, a, mem[widx(a)], shadow[widx(a)]); end
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd;
    logic er, clash, rdy;
    int lat, nrd, nwr;
    logic seen_resp = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h1001_0011; req_wdata = 32'h0000_005A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (memory_write !== 1'b0) begin errors++; $display("FAIL rst_store_write_gate got %b want 0", memory_write); end
    @(negedge clk);
    if (resp_valid) seen_resp = 1'b1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_store_ready_in_reset got %b want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    if (resp_valid) seen_resp = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_store_ready_after got %b want 1", req_ready); end
    checks++; if (seen_resp !== 1'b0) begin errors++; $display("FAIL rst_store_no_resp got %b want 0", seen_resp); end
    checks++; if (mem[4] !== shadow[4]) begin errors++; $display("FAIL rst_store_mem got %h want %h", mem[4], shadow[4]); end
    do_req(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0, rd, er, lat, nrd, nwr, clash, rdy);
    checks++; if (rd !== shadow[4] || er !== 1'b0 || lat != 2)
      begin errors++; $display("FAIL rst_store_reload got %h err=%b lat=%0d want %h err=0 lat=2", rd, er, lat, shadow[4]); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    test_reset();
    test_plan();
    test_random();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
